// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   CPU-side initiator for a word-only data memory. Takes byte, halfword and
//   word load/store requests from the datapath. Loads extract the addressed
//   lane and sign/zero-extend it. Sub-word stores do a read-modify-write of the
//   containing word. Misaligned or size=11 requests finish with err=1 and never
//   touch memory.
//
// Ports
//   Clock, Reset      : clock and synchronous active-high reset
//   req               : request strobe, sampled only while busy=0
//   wr, size, sign_ext: store/load, 00=B 01=H 10=W 11=illegal, load extension
//   addr, wdata       : byte address, store data (sub-word data in low bits)
//   busy, done, err   : busy while not IDLE; one-cycle done pulse with err
//   rdata             : last successful load result
//   mem_addr/mem_wdata/mem_we/mem_rdata : word memory port (combinational read)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_reg;
    logic              wr_reg;
    logic [1:0]        size_reg;
    logic              sign_reg;
    logic [1:0]        off_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       word_reg;
    logic [31:0]       rdata_reg;
    logic              done_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] mem_addr_reg;

    logic              req_bad;
    logic [31:0]       load_ext;
    logic [31:0]       merged_word;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;

    // Illegal size or an address not aligned to the access size.
    assign req_bad = (size == 2'b11) ||
                     (size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00);

    // Load lane extraction from the live memory read (little-endian lanes).
    assign load_byte = mem_rdata[8*off_reg +: 8];
    assign load_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (size_reg)
            2'b00:   load_ext = sign_reg ? {{24{load_byte[7]}}, load_byte} : {24'b0, load_byte};
            2'b01:   load_ext = sign_reg ? {{16{load_half[15]}}, load_half} : {16'b0, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Store word assembly, one byte lane at a time. A word store selects every
    // lane, so the captured word only matters for sub-word stores.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE    = 2'(gi);
            localparam logic       HALF_HI = (gi >= 2);
            logic       lane_sel;
            logic [7:0] lane_data;

            assign lane_sel  = (size_reg == 2'b10) ||
                               (size_reg == 2'b01 && off_reg[1] == HALF_HI) ||
                               (size_reg == 2'b00 && off_reg == LANE);
            assign lane_data = (size_reg == 2'b00) ? wdata_reg[7:0] :
                               (size_reg == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                                     wdata_reg[8*gi +: 8];
            assign merged_word[8*gi +: 8] = lane_sel ? lane_data : word_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= IDLE;
            wr_reg       <= 1'b0;
            size_reg     <= 2'b00;
            sign_reg     <= 1'b0;
            off_reg      <= 2'b00;
            wdata_reg    <= 32'b0;
            word_reg     <= 32'b0;
            rdata_reg    <= 32'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            mem_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    if (req) begin
                        wr_reg       <= wr;
                        size_reg     <= size;
                        sign_reg     <= sign_ext;
                        off_reg      <= addr[1:0];
                        wdata_reg    <= wdata;
                        mem_addr_reg <= {addr[ADDR_W-1:2], 2'b00};
                        if (req_bad) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end else if (wr && size == 2'b10) begin
                            state_reg <= WR;
                        end else begin
                            state_reg <= RD;
                        end
                    end
                end
                RD: begin
                    word_reg <= mem_rdata;
                    if (wr_reg) begin
                        state_reg <= WR;
                    end else begin
                        rdata_reg <= load_ext;
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                WR: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign err       = err_reg;
    assign rdata     = rdata_reg;
    assign mem_addr  = mem_addr_reg;
    // Reset gates the strobe combinationally so an abort never half-writes.
    assign mem_we    = (state_reg == WR) && !Reset;
    assign mem_wdata = (state_reg == WR) ? merged_word : 32'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    mem_access_unit #(.ADDR_W(32)) dut (
        .Clock(Clock), .Reset(Reset), .req(req), .wr(wr), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 Clock = ~Clock;

    // Memory the DUT drives, and a separate reference image of what it should hold.
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] ref_rdata;

    assign mem_rdata = mem[mem_addr[7:2]];

    int          we_cnt = 0;
    logic [31:0] we_data;
    logic [31:0] we_addr;

    always @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            we_cnt  = we_cnt + 1;
            we_data = mem_wdata;
            we_addr = mem_addr;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic sx, input logic [1:0] off);
        longint v;
        if (sz == 2'b10) return word;
        if (sz == 2'b00) begin
            v = (word >> (8 * off)) & 'hFF;
            if (sx && v >= 128) v = v - 256;
        end else begin
            v = (word >> (8 * off)) & 'hFFFF;
            if (sx && v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] mask;
        mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask = mask << (8 * off);
        return (old & ~mask) | ((wd << (8 * off)) & mask);
    endfunction

    // Issue one request, wait (bounded) for done, and compare against the model.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [7:0] a, input logic [31:0] wd);
        logic bad;
        int   lat;
        int   k;
        int   we0;
        int   idx;
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        lat = bad ? 1 : (!w || sz == 2'b10) ? 2 : 3;
        idx = int'(a[7:2]);
        @(negedge Clock);
        wr = w; size = sz; sign_ext = sx; addr = {24'b0, a}; wdata = wd; req = 1'b1;
        we0 = we_cnt;
        k = 0;
        do begin
            @(posedge Clock); #1;
            req = 1'b0;
            k++;
        end while (!done && k < 8);
        if (!bad && !w) ref_rdata = ref_load(ref_mem[idx], sz, sx, a[1:0]);
        if (!bad && w)  ref_mem[idx] = ref_store(ref_mem[idx], sz, a[1:0], wd);
        $display("req wr=%0d size=%0d sx=%0d addr=%h wdata=%h -> cycles=%0d err=%0d rdata=%h",
                 w, sz, sx, a, wd, k, err, rdata);
        chk("latency", k, lat);
        chk("err", {31'b0, err}, {31'b0, bad});
        chk("rdata", rdata, ref_rdata);
        chk("we_pulses", we_cnt - we0, (!bad && w) ? 1 : 0);
        if (!bad && w) chk("we_addr", we_addr, {24'b0, a[7:2], 2'b00});
        chk("mem_word", mem[idx], ref_mem[idx]);
        @(posedge Clock); #1;
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("idle_after", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int we0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'(i * i);
            ref_mem[i] = 32'(i * i);
        end
        ref_rdata = 32'd0;
        Reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge Clock);
        @(negedge Clock); Reset = 1'b0;
        #1;
        $display("reset: busy=%0d done=%0d err=%0d rdata=%h mem_addr=%h", busy, done, err, rdata, mem_addr);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // Directed sequence.
        run_req(1'b0, 2'b10, 1'b0, 8'h14, 32'd0);
        chk("lw_0x14", rdata, 32'h0000_0019);
        run_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hA5B6_C7D8);
        run_req(1'b0, 2'b00, 1'b1, 8'h10, 32'd0);
        chk("lb_0x10", rdata, 32'hFFFF_FFD8);
        run_req(1'b0, 2'b00, 1'b0, 8'h13, 32'd0);
        chk("lbu_0x13", rdata, 32'h0000_00A5);
        run_req(1'b0, 2'b01, 1'b1, 8'h12, 32'd0);
        chk("lh_0x12", rdata, 32'hFFFF_A5B6);
        run_req(1'b0, 2'b01, 1'b0, 8'h10, 32'd0);
        chk("lhu_0x10", rdata, 32'h0000_C7D8);
        run_req(1'b1, 2'b00, 1'b1, 8'h11, 32'hFFFF_FF7F);
        chk("sb_wdata", we_data, 32'hA5B6_7FD8);
        run_req(1'b1, 2'b01, 1'b0, 8'h12, 32'h0000_1234);
        run_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0);
        chk("lw_after_sh", rdata, 32'h1234_7FD8);
        run_req(1'b1, 2'b01, 1'b0, 8'h13, 32'h0000_BEEF);
        run_req(1'b0, 2'b10, 1'b0, 8'h16, 32'd0);
        run_req(1'b0, 2'b11, 1'b0, 8'h00, 32'd0);
        chk("err_rdata_kept", rdata, 32'h1234_7FD8);

        // Reset asserted during the WR cycle of a byte store to 0x08.
        @(negedge Clock);
        wr = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h08; wdata = 32'h55; req = 1'b1;
        @(posedge Clock); #1; req = 1'b0;
        @(posedge Clock); #1;
        chk("wr_state_we", {31'b0, mem_we}, 32'd1);
        we0 = we_cnt;
        Reset = 1'b1;
        #1;
        chk("reset_we_suppressed", {31'b0, mem_we}, 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        ref_rdata = 32'd0;
        $display("abort: busy=%0d done=%0d rdata=%h word2=%h", busy, done, rdata, mem[2]);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_we", we_cnt - we0, 32'd0);
        chk("abort_word2", mem[2], 32'h0000_0004);
        repeat (3) begin
            @(posedge Clock); #1;
            chk("abort_no_done", {31'b0, done}, 32'd0);
        end

        // req held high: one completed load every three cycles.
        @(negedge Clock);
        wr = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h04; req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge Clock); #1;
            $display("hold cycle=%0d done=%0d rdata=%h", k, done, rdata);
            chk("hold_done", {31'b0, done}, (k % 3 == 2) ? 32'd1 : 32'd0);
            if (done) chk("hold_rdata", rdata, 32'h0000_0001);
        end
        @(negedge Clock); req = 1'b0;
        ref_rdata = 32'h0000_0001;
        repeat (3) @(posedge Clock);

        // Randomized requests against the reference model.
        for (int t = 0; t < 60; t++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_req(1'($urandom), sz, 1'($urandom), 8'($urandom), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
